// File: rtl/bus_enable_arbiter.sv
// Round-robin owner selection for the shared 8-bit CPU data bus.
// Drives active-low '244 buffer enables and inserts a dead gap between owners.
module bus_enable_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int GAP_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         oe_n,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  // state | meaning
  // IDLE  | bus released, no owner, waiting for any request
  // GRANT | one requester owns the bus, hold counter running
  // GAP   | all buffers off for GAP_CYC cycles before next owner
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

  logic              sel_found;
  logic [OW-1:0]     sel_idx;
  logic [N_REQ-1:0]  sel_oh;
  logic              others_waiting;
  logic [OW-1:0]     rr_next;

  // Scan starts at rr_ptr and wraps, so the previous owner is considered last.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = OW'(idx);
      end
    end
    sel_oh          = '0;
    sel_oh[sel_idx] = 1'b1;
  end

  assign others_waiting = |(req & ~grant_q);
  assign rr_next = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (sel_found) begin
          state_d    = S_GRANT;
          grant_d    = sel_oh;
          owner_d    = sel_idx;
          hold_cnt_d = HW'(1);
        end
      end
      S_GRANT: begin
        if (!req[owner_q] || (hold_cnt_q == HW'(MAX_HOLD) && others_waiting)) begin
          state_d   = S_GAP;
          grant_d   = '0;
          rr_ptr_d  = rr_next;
          gap_cnt_d = GW'(GAP_CYC);
        end else if (hold_cnt_q != HW'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      S_GAP: begin
        grant_d   = '0;
        gap_cnt_d = gap_cnt_q - GW'(1);
        // rr_ptr was already advanced on release, so the new owner rotates.
        if (gap_cnt_q <= GW'(1)) begin
          if (sel_found) begin
            state_d    = S_GRANT;
            grant_d    = sel_oh;
            owner_d    = sel_idx;
            hold_cnt_d = HW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign grant = grant_q;
  assign oe_n  = ~grant_q;
  assign owner = owner_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_bus_enable_arbiter.sv
// Directed bench for bus_enable_arbiter: reset, rotation, hold limit,
// wrap-around, back-to-back handover and asynchronous reset mid-grant.
module tb_bus_enable_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] oe_n;
  logic [1:0] owner;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bus_enable_arbiter #(.N_REQ(4), .MAX_HOLD(8), .GAP_CYC(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .oe_n  (oe_n),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL onehot0 grant=%b", grant);
      end
      checks++;
      if (oe_n !== ~grant) begin
        errors++;
        $display("FAIL oe_n_inv oe_n=%b required=%b", oe_n, ~grant);
      end
      checks++;
      if (busy !== |grant) begin
        errors++;
        $display("FAIL busy busy=%b required=%b", busy, |grant);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    step();
    checks++;
    if (grant !== 4'b0000 || oe_n !== 4'hF || busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold grant=%b oe_n=%b busy=%b owner=%0d required 0000 1111 0 0",
               grant, oe_n, busy, owner);
    end
    step();
    rst = 1'b0;
    checks++;
    if (grant !== 4'b0000 || oe_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_release_noedge grant=%b oe_n=%b required 0000 1111", grant, oe_n);
    end
    step();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant grant=%b owner=%0d required 0001 0", grant, owner);
    end
  endtask

  // Continues from test_reset: all four requesting, first grant cycle to 0.
  task automatic test_round_robin();
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (grant !== seq[g]) begin
          errors++;
          $display("FAIL rr_grant slot=%0d cyc=%0d grant=%b required=%b", g, c, grant, seq[g]);
        end
        step();
      end
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap slot=%0d grant=%b required=0000", g, grant);
      end
      step();
    end
    req = 4'b0000;
  endtask

  task automatic test_single_hold();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (grant !== 4'b0100 || owner !== 2'd2) begin
        errors++;
        $display("FAIL single_grant cyc=%0d grant=%b owner=%0d required 0100 2", c, grant, owner);
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (grant !== 4'b0000 || owner !== 2'd2) begin
      errors++;
      $display("FAIL single_gap grant=%b owner=%0d required 0000 2", grant, owner);
    end
    step();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle grant=%b required 0000", grant);
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (grant !== 4'b0010) begin
        errors++;
        $display("FAIL no_preempt cyc=%0d grant=%b required 0010", c, grant);
      end
    end
    req = 4'b0000;
    step();
    step();
  endtask

  // Owner 0 saturates its hold count; a late contender gets the bus at once.
  task automatic test_late_contention();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL late_owner grant=%b required 0001", grant);
    end
    req = 4'b0011;
    step();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL late_release grant=%b required 0000", grant);
    end
    step();
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL late_next grant=%b owner=%0d required 0010 1", grant, owner);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0101;
    step();
    step();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_owner grant=%b required 0100", grant);
    end
    req = 4'b0001;
    step();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_gap grant=%b required 0000", grant);
    end
    step();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL wrap_grant grant=%b owner=%0d required 0001 0", grant, owner);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  // Old owner drops on the same edge a new one raises its request.
  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001;
    step();
    step();
    req = 4'b1000;
    step();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_gap grant=%b required 0000", grant);
    end
    step();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL b2b_grant grant=%b owner=%0d required 1000 3", grant, owner);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (oe_n !== 4'hF || grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset oe_n=%b grant=%b busy=%b required 1111 0000 0", oe_n, grant, busy);
    end
    #1;
    rst = 1'b0;
    req = 4'b1010;
    step();
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL reset_rr grant=%b owner=%0d required 0010 1", grant, owner);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_round_robin();
    test_single_hold();
    test_no_preempt();
    test_late_contention();
    test_wrap();
    test_back_to_back();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
